// File: rtl/stack_cpu_pkg.sv
// Shared definitions for the stack CPU datapath.
// Provides default widths/depths, pop_cnt encodings, the per-cycle legality
// record used by the operand stack, and the pop_cnt normalisation helper.
package stack_cpu_pkg;

  localparam int STACK_DBITS = 32;
  localparam int STACK_DEPTH = 16;

  localparam logic [1:0] POP0 = 2'd0;
  localparam logic [1:0] POP1 = 2'd1;
  localparam logic [1:0] POP2 = 2'd2;

  // Outcome of one stack cycle; exactly one field is set.
  typedef struct packed {
    logic legal;
    logic ovf;
    logic unf;
  } chk_t;

  // pop_cnt 3 is illegal and behaves like POP2.
  function automatic logic [1:0] eff_pop(input logic [1:0] pc);
    return (pc == 2'd3) ? POP2 : pc;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// Storage array for the operand stack.
// Ports: clk; one synchronous write port (we, waddr, wdata);
//        two asynchronous read ports (raddr0/rdata0, raddr1/rdata1).
// Contents are not reset.
module stack_ram #(
  parameter int DEPTH = 16,
  parameter int DBITS = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [DBITS-1:0] wdata,
  input  logic [AW-1:0]    raddr0,
  output logic [DBITS-1:0] rdata0,
  input  logic [AW-1:0]    raddr1,
  output logic [DBITS-1:0] rdata1
);

  logic [DBITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/operand_stack.sv
// Operand stack feeding the ALU: tos/nos are combinational reads of the top
// two entries; each cycle pops 0..2 entries then optionally pushes one.
// Ports: clk, reset (sync, active high); push, push_data, pop_cnt (request);
//        tos, nos (masked reads); count, empty, full; ovf_err, unf_err (sticky).
module operand_stack
  import stack_cpu_pkg::*;
#(
  parameter int DBITS = STACK_DBITS,
  parameter int DEPTH = STACK_DEPTH,
  parameter int CBITS = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [DBITS-1:0] push_data,
  input  logic [1:0]       pop_cnt,
  output logic [DBITS-1:0] tos,
  output logic [DBITS-1:0] nos,
  output logic [CBITS-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             ovf_err,
  output logic             unf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CBITS:0] DEPTH_X = (CBITS+1)'(DEPTH);

  logic [1:0]       p;
  logic [CBITS:0]   n_x;     // one extra bit so count+1 at DEPTH cannot wrap
  chk_t             chk;
  logic             we;
  logic [AW-1:0]    waddr, ra0, ra1;
  logic [DBITS-1:0] rd0, rd1;

  always_comb begin
    p         = eff_pop(pop_cnt);
    n_x       = {1'b0, count} - (CBITS+1)'(p) + (CBITS+1)'(push);
    chk.unf   = CBITS'(p) > count;
    chk.ovf   = !chk.unf && (n_x > DEPTH_X);
    chk.legal = !chk.unf && !chk.ovf;
  end

  // Address arithmetic is modulo DEPTH: at count == DEPTH the low bits are 0
  // and subtracting 1/2 lands on the correct top entries.
  assign we    = chk.legal && push && !reset;
  assign waddr = count[AW-1:0] - AW'(p);
  assign ra0   = count[AW-1:0] - AW'(1);
  assign ra1   = count[AW-1:0] - AW'(2);

  stack_ram #(.DEPTH(DEPTH), .DBITS(DBITS), .AW(AW)) u_ram (
    .clk    (clk),
    .we     (we),
    .waddr  (waddr),
    .wdata  (push_data),
    .raddr0 (ra0),
    .rdata0 (rd0),
    .raddr1 (ra1),
    .rdata1 (rd1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else if (chk.unf) begin
      unf_err <= 1'b1;
    end else if (chk.ovf) begin
      ovf_err <= 1'b1;
    end else begin
      count <= n_x[CBITS-1:0];
    end
  end

  // Memory is never cleared, so stale entries are hidden by masking on count.
  assign tos   = (count != '0)        ? rd0 : '0;
  assign nos   = (count >= CBITS'(2)) ? rd1 : '0;
  assign empty = (count == '0);
  assign full  = (count == CBITS'(DEPTH));

endmodule

// File: tb/tb_operand_stack.sv
module tb_operand_stack;

  localparam int DBITS = 32;
  localparam int DEPTH = 16;
  localparam int CBITS = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             push = 1'b0;
  logic [DBITS-1:0] push_data = '0;
  logic [1:0]       pop_cnt = 2'd0;
  logic [DBITS-1:0] tos, nos;
  logic [CBITS-1:0] count;
  logic             empty, full, ovf_err, unf_err;

  operand_stack #(.DBITS(DBITS), .DEPTH(DEPTH), .CBITS(CBITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop_cnt   (pop_cnt),
    .tos       (tos),
    .nos       (nos),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .ovf_err   (ovf_err),
    .unf_err   (unf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    int          cnt;
    logic [31:0] tos;
    logic [31:0] nos;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   issued = 0;
  int   checked = 0;

  function automatic void check(input string name, input int idx,
                                input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s vec%0d got=%h exp=%h", name, idx, got, exp);
    end
  endfunction

  // Monitor: after every rising edge that carried a vector, compare state.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checked++;
      check("count",   e.idx, 32'(count),   32'(e.cnt));
      check("tos",     e.idx, tos,          e.tos);
      check("nos",     e.idx, nos,          e.nos);
      check("empty",   e.idx, 32'(empty),   32'(e.cnt == 0));
      check("full",    e.idx, 32'(full),    32'(e.cnt == DEPTH));
      check("ovf_err", e.idx, 32'(ovf_err), 32'(e.ovf));
      check("unf_err", e.idx, 32'(unf_err), 32'(e.unf));
    end
  end

  task automatic step(input logic r, input logic ps, input logic [31:0] d,
                      input logic [1:0] pc, input int ecnt,
                      input logic [31:0] etos, input logic [31:0] enos,
                      input logic eovf, input logic eunf);
    exp_t e;
    reset = r; push = ps; push_data = d; pop_cnt = pc;
    @(posedge clk);
    e.idx = issued; e.cnt = ecnt; e.tos = etos; e.nos = enos;
    e.ovf = eovf; e.unf = eunf;
    q.push_back(e);
    issued++;
    @(negedge clk);
    #1;
    reset = 1'b0; push = 1'b0; pop_cnt = 2'd0;
  endtask

  initial begin
    // reset
    step(1, 1, 32'hDEAD, 0, 0, 0, 0, 0, 0);
    // push, push, binary op
    step(0, 1, 32'h00001000, 0, 1, 32'h00001000, 0, 0, 0);
    step(0, 1, 32'h00000001, 0, 2, 32'h00000001, 32'h00001000, 0, 0);
    step(0, 1, 32'h00001001, 2, 1, 32'h00001001, 0, 0, 0);
    // unary replace, then branch pop
    step(0, 1, 32'h00000001, 0, 2, 32'h00000001, 32'h00001001, 0, 0);
    step(0, 1, 32'hFFFFFFFF, 1, 2, 32'hFFFFFFFF, 32'h00001001, 0, 0);
    step(0, 0, 32'h0,        1, 1, 32'h00001001, 0, 0, 0);
    // underflow at count=1: ignored, sticky
    step(0, 1, 32'h00000005, 2, 1, 32'h00001001, 0, 0, 1);
    step(0, 1, 32'h00000003, 0, 2, 32'h00000003, 32'h00001001, 0, 1);
    // pop_cnt=3 acts as 2
    step(0, 1, 32'h000000AA, 3, 1, 32'h000000AA, 0, 0, 1);
    // reset clears flags; stale memory masked
    step(1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 32'h0, 1, 0, 0, 0, 0, 1);          // pop on empty
    step(1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    // fill to DEPTH
    for (int i = 0; i < DEPTH; i++)
      step(0, 1, 32'(i), 0, i + 1, 32'(i), (i == 0) ? 32'h0 : 32'(i - 1), 0, 0);
    // overflow push at full
    step(0, 1, 32'd99, 0, 16, 32'd15, 32'd14, 1, 0);
    // replace at full is legal
    step(0, 1, 32'd7,  1, 16, 32'd7,  32'd14, 1, 0);
    // binary op at full
    step(0, 1, 32'd0,  2, 15, 32'd0,  32'd13, 1, 0);
    step(0, 0, 32'd0,  0, 15, 32'd0,  32'd13, 1, 0);
    // pop down to 5: mem[14]=0 replaced top; remaining 0..13
    step(0, 0, 32'd0, 2, 13, 32'd12, 32'd11, 1, 0);
    step(0, 0, 32'd0, 2, 11, 32'd10, 32'd9,  1, 0);
    step(0, 0, 32'd0, 2, 9,  32'd8,  32'd7,  1, 0);
    step(0, 0, 32'd0, 2, 7,  32'd6,  32'd5,  1, 0);
    step(0, 0, 32'd0, 2, 5,  32'd4,  32'd3,  1, 0);
    // reset with push in the same cycle: reset wins, no write
    step(1, 1, 32'h12345678, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h00000055, 0, 1, 32'h00000055, 0, 0, 0);
    step(0, 1, 32'h00000066, 0, 2, 32'h00000066, 32'h00000055, 0, 0);

    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0 || checked != issued) begin
      bad++;
      $display("FAIL drain got=%0d exp=%0d", checked, issued);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_stack.md
# operand_stack

Hardware operand stack for the single-cycle stack CPU. It sits directly upstream of the ALU: it presents the top two entries as the ALU's `operand1` (next-on-stack) and `operand2` (top-of-stack), and in the same clock edge pops the consumed operands and pushes the ALU result, or a literal, back. Reads are combinational and writes commit on the rising clock edge, so one instruction completes per cycle.

## Interface

Parameters:
- `DBITS`, 32: entry width; matches ALU operand width.
- `DEPTH`, 16: number of entries; must be a power of two, at least 4.
- `CBITS`, $clog2(DEPTH)+1: width of `count`.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the `clk` rising edge.
- `push`  in  1  write `push_data` as the new top this cycle.
- `push_data`  in  DBITS  value to push (ALU result or immediate).
- `pop_cnt`  in  2  entries to remove this cycle: 0, 1 or 2; value 3 is illegal and treated as 2.
- `tos`  out  DBITS  top entry, combinational; feeds ALU `operand2`.
- `nos`  out  DBITS  entry below top, combinational; feeds ALU `operand1`.
- `count`  out  CBITS  current number of valid entries.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.
- `ovf_err`  out  1  sticky overflow flag.
- `unf_err`  out  1  sticky underflow flag.

## Operation

- Storage: an array of DEPTH entries. Entry `count-1` is the top.
- Read side:
  - `tos = mem[count-1]` when `count >= 1`, otherwise 0.
  - `nos = mem[count-2]` when `count >= 2`, otherwise 0.
- Per cycle, the pops are applied first and the push second:
  - Let `p = pop_cnt`, with 3 mapped to 2.
  - Let `n = count - p + push`.
- Legal cycle (`p <= count` and `n <= DEPTH`):
  - If `push`, write `push_data` to `mem[count - p]`.
  - Set `count <= n`.
- Underflow (`p > count`):
  - The whole cycle is ignored: no write, `count` unchanged.
  - `unf_err <= 1`.
- Overflow (`p <= count` and `n > DEPTH`):
  - The whole cycle is ignored.
  - `ovf_err <= 1`.
  - When full, `push` with `p >= 1` is legal because it replaces entries.
- Typical ALU uses:
  - Binary op (add, sub, mult, and, or, xor, eq, gt, leq): `p=2`, `push=1`.
  - Unary op (negi, noti): `p=1`, `push=1`, result replaces `tos`.
  - branch_zero / branch_nzero: `p=1`, `push=0`.
  - Literal push: `p=0`, `push=1`.
- The sticky flags are cleared only by `reset`.
- Memory contents are not reset. The zero-masking of `tos` and `nos` keeps stale data invisible.

## Timing

- On reset:
  - `count=0`, `empty=1`, `full=0`, `ovf_err=0`, `unf_err=0`, `tos=0`, `nos=0`.
- Reset priority:
  - `reset` overrides `push` and `pop_cnt` in the same cycle.
  - No write occurs while `reset` is high.
- Read latency: zero cycles. `tos` and `nos` depend only on `count` and `mem`.
  - The ALU result computed from them in cycle N is pushed at the end of cycle N.
- Write latency: one edge. New `count`, `tos` and `nos` are visible right after the rising edge.
- Flag timing:
  - `ovf_err` and `unf_err` rise on the edge of the offending cycle.
  - `empty` and `full` are combinational from `count`.
- No combinational path exists from `push`, `push_data` or `pop_cnt` to any output.

## Structure

- Shared package `stack_cpu_pkg`:
  - `DBITS` default.
  - `STACK_DEPTH` default.
  - `pop_cnt` encodings `POP0=2'd0`, `POP1=2'd1`, `POP2=2'd2`.
- Sub-module `stack_ram`:
  - DEPTH x DBITS.
  - One synchronous write port (`we`, `waddr`, `wdata`).
  - Two asynchronous read ports (`raddr0`, `raddr1`).
- `operand_stack` itself holds the count register, the legality checks, the sticky flags and the output masking.

## Test plan

- **Reset:** assert `reset` one cycle → `count=0`, `empty=1`, `tos=0`, `nos=0`, both error flags 0.
- **Push and binary op:**
  - Push 32'h00001000, then push 32'h00000001 → `nos=00001000`, `tos=00000001`, `count=2`.
  - Then `p=2`, `push=1`, `push_data=32'h00001001` → `count=1`, `tos=00001001`, `nos=0`.
- **Unary replace and branch pop:**
  - With `tos=00000001`: `p=1`, `push=1`, data FFFFFFFF → `count` unchanged, `tos=FFFFFFFF`.
  - Then `p=1`, `push=0` → `count` decrements by 1.
- **Full boundary:**
  - Push 16 values 0..15 → `full=1`, `tos=15`.
  - Push 99 with `p=0` → `ovf_err=1`, `count=16`, `tos=15`.
  - Then `p=1`, `push=1`, data 7 → legal, `tos=7`, `count=16`.
- **Underflow:** with `count=1`, `p=2`, `push=1` → `unf_err=1`, `count=1`, `tos` unchanged, flag stays set on later legal cycles.
- **Reset mid-operation:** `count=5`, `ovf_err=1`, assert `reset` together with `push=1` → next cycle `count=0`, both flags 0, `tos=0`.
